// File: rtl/meas_pkg.sv
// Shared definitions for the measurement predictor / residual packer path.
package meas_pkg;

  localparam int MEA_N   = 8;             // residuals per block
  localparam int RES_WID = 13;            // signed residual width
  localparam int OUT_WID = 32;            // packed output word width
  localparam int ACC_WID = 64;            // bit accumulator width
  localparam int MAX_CW  = 2*RES_WID + 1; // longest Exp-Golomb codeword

  localparam int FILL_W = $clog2(ACC_WID + 1);
  localparam int LEN_W  = $clog2(MAX_CW + 1);
  localparam int IDX_W  = $clog2(MEA_N);

  // Prediction mode codes carried in the 2-bit block header
  localparam logic signed [1:0] CODE_CONST = -2'sd1;
  localparam logic signed [1:0] CODE_LEFT  =  2'sd0;
  localparam logic signed [1:0] CODE_TOP   =  2'sd1;

  typedef logic signed [RES_WID-1:0] res_t;
  typedef res_t res_vec_t [MEA_N];

endpackage

// File: rtl/meas_res_packer_if.sv
// Block-input and packed-word-output channels of the residual packer.
interface meas_res_packer_if;
  import meas_pkg::*;

  logic               in_valid;
  logic               in_ready;
  res_vec_t           y_resQ;
  logic signed [1:0]  code;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [OUT_WID-1:0] out_data;
  logic               out_last;
  logic               busy;

  modport master (
    output in_valid, y_resQ, code, flush, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy
  );

  modport slave (
    input  in_valid, y_resQ, code, flush, out_ready,
    output in_ready, out_valid, out_data, out_last, busy
  );

endinterface

// File: rtl/meas_res_packer_eg0_encoder.sv
// Signed order-0 Exp-Golomb encoder: right-aligned codeword plus its length.
module eg0_encoder
  import meas_pkg::*;
(
  input  res_t               res,
  output logic [MAX_CW-1:0]  cw,
  output logic [LEN_W-1:0]   len
);

  logic [RES_WID:0]  k;
  logic [RES_WID:0]  kp1;
  logic [LEN_W-1:0]  m;

  // Signed-to-unsigned mapping, then m = floor(log2(k+1)) by priority encode
  always_comb begin
    if (res > 0) k = {res, 1'b0} - {{RES_WID{1'b0}}, 1'b1};
    else         k = ~{res, 1'b0} + {{RES_WID{1'b0}}, 1'b1};
    kp1 = k + {{RES_WID{1'b0}}, 1'b1};
    m   = '0;
    for (int i = 0; i <= RES_WID; i++) begin
      if (kp1[i]) m = LEN_W'(i);
    end
    // m leading zeros followed by k+1 is exactly k+1 right-aligned in 2m+1 bits
    len = {m[LEN_W-2:0], 1'b1};
    cw  = {{(MAX_CW-RES_WID-1){1'b0}}, kp1};
  end

endmodule

// File: rtl/meas_res_packer.sv
// Packs a 2-bit mode header and MEA_N Exp-Golomb residuals MSB-first into words.
module meas_res_packer
  import meas_pkg::*;
(
  input  logic              clk,
  input  logic              arst,
  meas_res_packer_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_HDR   = 2'd1;
  localparam logic [1:0] S_RES   = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  localparam logic [FILL_W-1:0] OUT_WID_F = FILL_W'(OUT_WID);
  localparam logic [LEN_W-1:0]  MAX_CW_L  = LEN_W'(MAX_CW);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(MEA_N - 1);

  logic [1:0]          state;
  logic [FILL_W-1:0]   fill;
  logic [ACC_WID-1:0]  acc;
  logic                flush_pend;
  logic [IDX_W-1:0]    idx;
  res_vec_t            res_q;
  logic [1:0]          code_q;

  logic [MAX_CW-1:0]   eg_cw;
  logic [LEN_W-1:0]    eg_len;
  logic                accept;
  logic                flush_req;
  logic                app_en;
  logic                last_word;
  logic                word_rdy;
  logic                pop;
  logic [MAX_CW-1:0]   sym_cw;
  logic [MAX_CW-1:0]   sym_la;
  logic [LEN_W-1:0]    sym_len;
  logic [FILL_W-1:0]   fill_base;
  logic [FILL_W-1:0]   fill_next;
  logic [ACC_WID-1:0]  acc_base;
  logic [ACC_WID-1:0]  acc_ins;
  logic [ACC_WID-1:0]  acc_next;

  eg0_encoder u_eg0 (
    .res (res_q[idx]),
    .cw  (eg_cw),
    .len (eg_len)
  );

  assign accept    = (state == S_IDLE) && bus.in_valid;
  assign flush_req = flush_pend || bus.flush;
  // Appending only below one word of fill keeps the accumulator from overflowing
  assign app_en    = ((state == S_HDR) || (state == S_RES)) && (fill < OUT_WID_F);
  // In FLUSH a partial word is presented as already zero-padded
  assign last_word = (state == S_FLUSH) && (fill != '0) && (fill < OUT_WID_F);
  assign word_rdy  = (fill >= OUT_WID_F) || last_word;
  assign pop       = word_rdy && bus.out_ready;

  // Select the symbol for this cycle and left-align it within MAX_CW bits
  always_comb begin
    sym_cw  = '0;
    sym_len = '0;
    if (state == S_HDR) begin
      sym_cw  = {{(MAX_CW-2){1'b0}}, code_q};
      sym_len = LEN_W'(2);
    end else if (state == S_RES) begin
      sym_cw  = eg_cw;
      sym_len = eg_len;
    end
    sym_la = '0;
    if (app_en) sym_la = sym_cw << (MAX_CW_L - sym_len);
  end

  // Pop first, then insert the new symbol directly below the remaining fill
  always_comb begin
    fill_base = fill;
    acc_base  = acc;
    if (pop) begin
      acc_base  = acc << OUT_WID;
      fill_base = last_word ? '0 : (fill - OUT_WID_F);
    end
    acc_ins   = {sym_la, {(ACC_WID-MAX_CW){1'b0}}} >> fill_base;
    acc_next  = acc_base | acc_ins;
    fill_next = fill_base + (app_en ? FILL_W'(sym_len) : '0);
  end

  // Control state: FSM, symbol index, pending flush and the bit accumulator
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state      <= S_IDLE;
      fill       <= '0;
      acc        <= '0;
      flush_pend <= 1'b0;
      idx        <= '0;
    end else begin
      fill <= fill_next;
      acc  <= acc_next;
      case (state)
        S_IDLE: begin
          if (accept) begin
            state      <= S_HDR;
            flush_pend <= flush_pend | bus.flush;
          end else if (flush_req) begin
            flush_pend <= 1'b0;
            if (fill != '0) state <= S_FLUSH;
          end
        end
        S_HDR: begin
          flush_pend <= flush_pend | bus.flush;
          if (app_en) begin
            state <= S_RES;
            idx   <= '0;
          end
        end
        S_RES: begin
          flush_pend <= flush_pend | bus.flush;
          if (app_en) begin
            if (idx == IDX_LAST) begin
              state <= S_IDLE;
              idx   <= '0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        S_FLUSH: begin
          // Any flush seen here is satisfied by the flush already in progress
          flush_pend <= 1'b0;
          if ((fill == '0) || (pop && last_word)) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Block payload registers, loaded on acceptance only
  always_ff @(posedge clk) begin
    if (accept) begin
      res_q  <= bus.y_resQ;
      code_q <= bus.code;
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = word_rdy;
  assign bus.out_data  = acc[ACC_WID-1 -: OUT_WID];
  assign bus.out_last  = last_word;
  assign bus.busy      = (state != S_IDLE) || (fill != '0);

endmodule
